// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry add/subtract: CHUNK bits resolved per stage, carry handed stage to stage.
// Handshake: a beat moves on a rising edge where valid && ready; producers hold valid and payload until then.
module pipelined_adder #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int STAGES = WIDTH / CHUNK;

    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             c_q [STAGES];
    logic             v_q [STAGES];
    logic             ovf_q;

    logic [WIDTH-1:0] a_d [STAGES];
    logic [WIDTH-1:0] b_d [STAGES];
    logic [WIDTH-1:0] s_d [STAGES];
    logic             c_d [STAGES];
    logic             v_d [STAGES];
    logic             ovf_d;

    // Per-stage inputs: stage 0 sees the operands, stage k sees stage k-1's registers.
    logic [WIDTH-1:0] a_src [STAGES];
    logic [WIDTH-1:0] b_src [STAGES];
    logic [WIDTH-1:0] s_src [STAGES];
    logic             c_src [STAGES];
    logic             v_src [STAGES];
    logic [CHUNK:0]   slice [STAGES];

    logic adv;

    // The whole pipeline moves or holds together; only a stalled valid result blocks it.
    assign adv      = !v_q[STAGES-1] || out_ready;
    assign in_ready = adv;

    always_comb begin
        a_src[0] = a;
        b_src[0] = op ? ~b : b;
        c_src[0] = op ? 1'b1 : cin;
        s_src[0] = '0;
        v_src[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_src[k] = a_q[k-1];
            b_src[k] = b_q[k-1];
            c_src[k] = c_q[k-1];
            s_src[k] = s_q[k-1];
            v_src[k] = v_q[k-1];
        end
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            slice[k] = {1'b0, a_src[k][k*CHUNK +: CHUNK]}
                     + {1'b0, b_src[k][k*CHUNK +: CHUNK]}
                     + {{CHUNK{1'b0}}, c_src[k]};
            a_d[k] = a_src[k];
            b_d[k] = b_src[k];
            s_d[k] = s_src[k];
            s_d[k][k*CHUNK +: CHUNK] = slice[k][CHUNK-1:0];
            c_d[k] = slice[k][CHUNK];
            v_d[k] = v_src[k];
        end
        // Same-sign operands producing an opposite-sign result is exactly carry-in(MSB) ^ carry-out(MSB).
        ovf_d = (a_src[STAGES-1][WIDTH-1] == b_src[STAGES-1][WIDTH-1])
             && (s_d[STAGES-1][WIDTH-1] != a_src[STAGES-1][WIDTH-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
                v_q[k] <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
                c_q[k] <= c_d[k];
                v_q[k] <= v_d[k];
            end
            ovf_q <= ovf_d;
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed vector table, backpressure stream, mid-flight reset, geometry sweep.
module tb_pipelined_adder;
    localparam int W      = 64;
    localparam int C      = 16;
    localparam int STAGES = W / C;

    logic clk = 1'b0;
    logic rst_n, sw_rst_n;
    logic in_valid, in_ready, cin, op, out_valid, out_ready, cout, ovf;
    logic [W-1:0] a, b, sum;

    int errors = 0;
    int checks = 0;
    int sweep_done = 0;

    logic [65:0] exp_q[$];
    int          age_q[$];
    logic        prev_stall;
    logic [65:0] prev_out;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic        op;
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[11];

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(W), .CHUNK(C)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    task automatic check(input string nm, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: {cout, ovf, sum} for a w-bit unit, overflow judged by signed range.
    function automatic logic [65:0] model(input logic [63:0] ma, input logic [63:0] mb,
                                          input logic mc, input logic mo, input int w);
        logic [63:0]        mask, bb, s, ta, tb;
        logic [64:0]        full;
        logic signed [65:0] sa, sb, r, lim;
        logic               co, ov;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        bb   = mo ? (~mb & mask) : mb;
        full = {1'b0, ma} + {1'b0, bb} + {64'd0, (mo ? 1'b1 : mc)};
        s    = full[63:0] & mask;
        co   = mo ? (ma >= mb) : full[w];
        ta   = ma << (64 - w);
        tb   = mb << (64 - w);
        sa   = {{2{ta[63]}}, ta};
        sb   = {{2{tb[63]}}, tb};
        sa   = sa >>> (64 - w);
        sb   = sb >>> (64 - w);
        r    = mo ? (sa - sb) : (sa + sb + {65'd0, mc});
        lim  = 66'sd1 <<< (w - 1);
        ov   = (r >= lim) || (r < -lim);
        return {co, ov, s};
    endfunction

    task automatic apply_vec(input vec_t v, input string nm);
        int n;
        @(negedge clk);
        in_valid = 1'b1; a = v.a; b = v.b; cin = v.cin; op = v.op; out_ready = 1'b1;
        #1;
        check({nm, "_in_ready"}, 66'(in_ready), 66'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n = 1;
        while (!out_valid && n < 16) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({nm, "_latency"}, 66'(n), 66'(STAGES));
        check({nm, "_sum"}, 66'(sum), 66'(v.sum));
        check({nm, "_cout"}, 66'(cout), 66'(v.cout));
        check({nm, "_ovf"}, 66'(ovf), 66'(v.ovf));
    endtask

    // Scoreboard step for the main unit, called #1 into each low clock phase.
    task automatic sb_main(input logic [65:0] beat_exp);
        logic [65:0] got;
        got = {cout, ovf, sum};
        if (prev_stall) begin
            check("hold_valid", 66'(out_valid), 66'd1);
            check("hold_data", got, prev_out);
        end
        if (out_valid && !out_ready) check("in_ready_stall", 66'(in_ready), 66'd0);
        else                         check("in_ready_flow", 66'(in_ready), 66'd1);
        if (exp_q.size() > 0 && age_q[0] >= STAGES) check("no_gap", 66'(out_valid), 66'd1);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 66'(out_valid), 66'd0);
            end else begin
                check("stream_data", got, exp_q[0]);
                check("stream_latency", 66'(age_q[0]), 66'(STAGES));
                void'(exp_q.pop_front());
                void'(age_q.pop_front());
            end
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(beat_exp);
            age_q.push_back(0);
        end
        if (!out_valid || out_ready) foreach (age_q[i]) age_q[i]++;
        prev_stall = out_valid && !out_ready;
        prev_out   = got;
    endtask

    initial begin
        logic [63:0] ra, rb;
        logic        rc, ro;
        int          sent;

        vecs[0]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0};
        vecs[1]  = '{64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        vecs[2]  = '{64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1, 1'b0};
        vecs[3]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vecs[4]  = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
        vecs[5]  = '{64'd0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0};
        vecs[6]  = '{64'h0000_FFFF_0000_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_FFFF_0001_0000, 1'b0, 1'b0};
        vecs[7]  = '{64'd10, 64'd3, 1'b1, 1'b1, 64'd7, 1'b1, 1'b0};
        vecs[8]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
        vecs[9]  = '{64'd0, 64'd0, 1'b0, 1'b1, 64'd0, 1'b1, 1'b0};
        vecs[10] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'd0, 1'b1, 1'b1};

        rst_n = 1'b0; sw_rst_n = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; op = 1'b0; out_ready = 1'b1;
        prev_stall = 1'b0; prev_out = '0;
        #1;
        check("reset_out_valid", 66'(out_valid), 66'd0);
        check("reset_data", {cout, ovf, 64'(sum)}, 66'd0);
        check("reset_in_ready", 66'(in_ready), 66'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1; sw_rst_n = 1'b1;

        for (int i = 0; i < 11; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

        // Back-to-back stream with a three-cycle downstream stall in the middle.
        sent = 0;
        ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
        rc = 1'($urandom_range(0, 1)); ro = 1'($urandom_range(0, 1));
        for (int w = 0; w < 60 && (sent < 10 || exp_q.size() > 0); w++) begin
            @(negedge clk);
            in_valid = (sent < 10); a = ra; b = rb; cin = rc; op = ro;
            out_ready = !(w >= 5 && w <= 7);
            #1;
            sb_main(model(ra, rb, rc, ro, W));
            if (in_valid && in_ready) begin
                sent++;
                ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
                rc = 1'($urandom_range(0, 1)); ro = 1'($urandom_range(0, 1));
            end
        end
        in_valid = 1'b0;
        check("bp_all_sent", 66'(sent), 66'd10);
        check("bp_drained", 66'(exp_q.size()), 66'd0);

        // Three beats in flight, first one parked at the output, then an asynchronous reset pulse.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 64'h11 * (i + 1); b = 64'h100; cin = 1'b0; op = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        #1;
        check("rst_pre_valid", 66'(out_valid), 66'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", 66'(out_valid), 66'd0);
        check("rst_async_data", {cout, ovf, 64'(sum)}, 66'd0);
        check("rst_in_ready", 66'(in_ready), 66'd1);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        exp_q.delete(); age_q.delete(); prev_stall = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            check("rst_no_ghost", 66'(out_valid), 66'd0);
        end
        apply_vec('{64'd1, 64'd1, 1'b0, 1'b0, 64'd2, 1'b0, 1'b0}, "post_rst");

        for (int t = 0; t < 5000 && sweep_done < 4; t++) @(negedge clk);
        check("sweep_done", 66'(sweep_done), 66'd4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Geometry sweep: random beats with random gaps and random downstream stalls.
    for (genvar g = 0; g < 4; g++) begin : g_sweep
        localparam int SW = (g == 0) ? 64 : (g == 1) ? 64 : (g == 2) ? 32 : 4;
        localparam int SC = (g == 0) ? 64 : (g == 1) ? 8  : (g == 2) ? 4  : 1;
        localparam int SS = SW / SC;

        logic s_in_valid, s_in_ready, s_cin, s_op, s_out_valid, s_out_ready, s_cout, s_ovf;
        logic [SW-1:0] s_a, s_b, s_sum;
        logic [65:0] exp_q[$];
        int          age_q[$];

        pipelined_adder #(.WIDTH(SW), .CHUNK(SC)) dut (
            .clk(clk), .rst_n(sw_rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
            .a(s_a), .b(s_b), .cin(s_cin), .op(s_op), .out_valid(s_out_valid),
            .out_ready(s_out_ready), .sum(s_sum), .cout(s_cout), .ovf(s_ovf)
        );

        initial begin
            logic [63:0] ra, rb, mask;
            logic        rc, ro, pend, stall;
            logic [65:0] got, last;
            int          sent;
            mask = (SW == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << SW) - 64'd1);
            ra = '0; rb = '0; rc = 1'b0; ro = 1'b0; pend = 1'b0; stall = 1'b0; last = '0; sent = 0;
            s_in_valid = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0; s_op = 1'b0; s_out_ready = 1'b1;
            wait (sw_rst_n === 1'b1);
            for (int w = 0; w < 400 && (sent < 20 || pend || exp_q.size() > 0); w++) begin
                @(negedge clk);
                if (!pend && sent < 20 && $urandom_range(0, 3) != 0) begin
                    ra = {$urandom, $urandom} & mask; rb = {$urandom, $urandom} & mask;
                    rc = 1'($urandom_range(0, 1)); ro = 1'($urandom_range(0, 1));
                    pend = 1'b1;
                end
                s_in_valid = pend; s_a = ra[SW-1:0]; s_b = rb[SW-1:0]; s_cin = rc; s_op = ro;
                s_out_ready = ($urandom_range(0, 3) != 0);
                #1;
                got = {s_cout, s_ovf, 64'(s_sum)};
                if (stall) begin
                    check($sformatf("sw%0d_hold_valid", g), 66'(s_out_valid), 66'd1);
                    check($sformatf("sw%0d_hold_data", g), got, last);
                end
                if (exp_q.size() > 0 && age_q[0] >= SS)
                    check($sformatf("sw%0d_no_gap", g), 66'(s_out_valid), 66'd1);
                if (s_out_valid && s_out_ready) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("sw%0d_spurious", g), 66'(s_out_valid), 66'd0);
                    end else begin
                        check($sformatf("sw%0d_data", g), got, exp_q[0]);
                        check($sformatf("sw%0d_latency", g), 66'(age_q[0]), 66'(SS));
                        void'(exp_q.pop_front());
                        void'(age_q.pop_front());
                    end
                end
                if (pend && s_in_ready) begin
                    exp_q.push_back(model(ra, rb, rc, ro, SW));
                    age_q.push_back(0);
                    pend = 1'b0;
                    sent++;
                end
                if (!s_out_valid || s_out_ready) foreach (age_q[i]) age_q[i]++;
                stall = s_out_valid && !s_out_ready;
                last  = got;
            end
            s_in_valid = 1'b0;
            check($sformatf("sw%0d_all_sent", g), 66'(sent), 66'd20);
            check($sformatf("sw%0d_drained", g), 66'(exp_q.size()), 66'd0);
            sweep_done++;
        end
    end

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined ripple-carry add/subtract unit: a WIDTH-bit operand pair is split into CHUNK-bit slices and the carry ripples through one slice per clock stage. Operands enter and results leave through valid/ready handshakes, at one result per cycle. It is the registered, wide-datapath successor to the 4-bit combinational ripple adder cell. It serves as the final carry-propagate stage behind the carry-save tree.

## Interface
- WIDTH, 64, operand and result width; must be a multiple of CHUNK.
- CHUNK, 16, bits resolved per pipeline stage; STAGES = WIDTH/CHUNK, and STAGES ≥ 1.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  unit can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; used only when op=0.
- op  input  1  0 = add (A+B+cin), 1 = subtract (A-B).
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of the MSB; for subtract, 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.

## Operation
- Subtract: internal B' = ~b, internal carry-in = 1, and cin is ignored. Add: B' = b, carry-in = cin.
- Stage k (k = 0..STAGES-1) adds slice k of A and B' plus the carry registered from stage k-1. Stage 0 uses the internal carry-in.
- Each stage registers:
  - its sum slice,
  - its carry,
  - the not-yet-consumed upper slices of A/B' (skew registers),
  - the already-computed lower sum slices,
  - a valid bit.
- The last stage registers:
  - the full sum;
  - cout = carry out of slice STAGES-1;
  - ovf = carry into MSB XOR carry out of MSB.
- All arithmetic is modulo 2^WIDTH. No saturation.
- Global stall: adv = !out_valid || out_ready. When adv=1, every stage loads from its predecessor, bubbles included. When adv=0, every stage holds.
- in_ready = adv. A beat is accepted when in_valid && in_ready.
- A bubble enters stage 0 (valid=0) when adv && !in_valid.
- Results emerge strictly in acceptance order. No beat is dropped or duplicated.
- While out_valid && !out_ready, sum, cout and ovf stay stable.

## Timing
- Latency: a beat accepted at edge t appears with out_valid=1 after edge t+STAGES-1, i.e. STAGES register stages. For the defaults that is 4 cycles, edge-to-edge.
- Throughput: 1 beat/cycle while out_ready is held high.
- in_ready is combinational from out_ready and out_valid. No other combinational input-to-output path exists.
- Reset (rst_n low, asynchronous):
  - all valid bits = 0;
  - all data, carry and skew registers = 0;
  - out_valid=0, sum=0, cout=0, ovf=0.
- in_ready = 1 during and after reset, because out_valid=0.
- Reset mid-operation discards every in-flight beat. The first beat accepted after release emerges at the normal latency.
- A beat is accepted on the same cycle a result is consumed (adv=1): both transfers occur and occupancy is unchanged.
- Full pipeline with out_ready low: in_ready=0 and the stage contents are frozen. When out_ready rises, the flow resumes with no loss.
- STAGES=1 (CHUNK=WIDTH): single-register adder with latency 1 and the same handshake.
- in_valid low for N cycles inserts N bubbles. out_valid is low for the corresponding N cycles, STAGES later.

## Test plan
- Defaults, add: a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> sum=0, cout=1, ovf=0, out_valid exactly 4 cycles after acceptance. This exercises the carry rippling through all 4 chunk boundaries.
- Subtract: a=5, b=7, op=1 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0. Also a=7, b=5 -> sum=2, cout=1.
- Signed overflow:
  - add a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> sum=0x8000_0000_0000_0000, ovf=1, cout=0;
  - subtract a=0x8000_0000_0000_0000, b=1 -> sum=0x7FFF_FFFF_FFFF_FFFF, ovf=1, cout=1.
- Backpressure: stream 10 back-to-back random beats and drive out_ready low for 3 cycles mid-stream. Required:
  - in_ready falls as soon as out_valid is high with out_ready low;
  - outputs stay stable during the stall;
  - all 10 results match a reference model in order, with no gaps once out_ready returns high.
- Reset mid-flight: accept 3 beats, then pulse rst_n low for 1 cycle between clock edges. Required:
  - out_valid=0 and sum=0 immediately, asynchronously;
  - none of the 3 results ever appear;
  - a new beat of 1+1 gives sum=2 after 4 cycles.
- Parameter sweep: repeat the random test with (WIDTH, CHUNK) = (64,64), (64,8), (32,4), (4,1). Required: latency = WIDTH/CHUNK and all results match the model.
